// File: rtl/ram_read_check.sv
// rtl/ram_read_check.sv - read-side sweeper/checker for the 2-port RAM test
// Sweeps addresses 0..DEPTH-1 and checks q against (addr + SEED) after the read latency.
module ram_read_check #(
  parameter int DEPTH  = 1024,
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 2,
  parameter int SEED   = 0
) (
  input  logic          rdclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] q,
  output logic [AW-1:0] address_b,
  output logic          rden_b,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_rden, w_rden_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pass, w_pass_nxt;
  logic [AW:0]   r_err, w_err_nxt;
  logic [AW-1:0] r_first, w_first_nxt;

  // Stage 0 mirrors the RAM input register; stages 1..RD_LAT mirror its read latency.
  logic [RD_LAT:0] r_vld;
  logic [AW-1:0]   r_tag [RD_LAT+1];

  logic          w_accept, w_last, w_empty, w_miss;
  logic [DW-1:0] w_exp;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_addr == LAST_ADDR);
  assign w_empty  = ~|r_vld;
  assign w_exp    = DW'(r_tag[RD_LAT]) + DW'(SEED);
  assign w_miss   = r_vld[RD_LAT] && (q != w_exp);

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rden  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rden  <= w_rden_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)   w_state_nxt = S_READ;
      S_READ:         if (w_last)  w_state_nxt = S_DRAIN;
      S_DRAIN:        if (w_empty) w_state_nxt = S_DONE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_nxt  = r_addr;
    w_rden_nxt  = r_rden;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_addr_nxt = '0;
          w_rden_nxt = 1'b1;
          w_busy_nxt = 1'b1;
          w_done_nxt = 1'b0;
          w_pass_nxt = 1'b0;
        end
      end
      S_READ: begin
        if (w_last) w_rden_nxt = 1'b0;
        else        w_addr_nxt = r_addr + AW'(1);
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
          w_pass_nxt = (r_err == '0);
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      w_err_nxt   = '0;
      w_first_nxt = '0;
    end else if (w_miss) begin
      if (r_err != '1) w_err_nxt = r_err + (AW+1)'(1);
      if (r_err == '0) w_first_nxt = r_tag[RD_LAT];
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_vld    <= {r_vld[RD_LAT-1:0], r_rden};
      r_tag[0] <= r_addr;
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign address_b      = r_addr;
  assign rden_b         = r_rden;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_err_addr = r_first;

endmodule

// File: doc/ram_read_check.md
Name: ram_read_check

Overview:
- Read-side sweeper/checker for the 2-port RAM test.
- On a start pulse, drives the RAM read port through addresses 0..DEPTH-1 and aligns the returned q with a delayed copy of each issued address, allowing for the RAM read latency.
- Compares every word against the write-side pattern (data = address[7:0] + SEED) and reports mismatch count, first failing address, and pass/done flags.
- Sits beside the write-side controller; one sweep per start.

Parameters:
- DEPTH, 1024, number of words swept; power of two, 2..1024.
- AW, 10, address width; must satisfy 2^AW >= DEPTH.
- DW, 8, data width.
- RD_LAT, 2, cycles from address/rden_b registered at the RAM to valid q (1..4).
- SEED, 0, expected-pattern offset; expected = (addr + SEED) mod 2^DW.

Ports:
- rdclk  input  1  single clock; everything is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when the block is idle or done.
- q  input  DW  RAM read data.
- address_b  output  AW  RAM read address.
- rden_b  output  1  RAM read enable.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid when done; 1 if err_cnt == 0.
- err_cnt  output  AW+1  number of mismatches in the current sweep; saturates at 2^(AW+1)-1.
- first_err_addr  output  AW  address of the first mismatch; 0 if there is none.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE.
  - All outputs go to 0: address_b, rden_b, busy, done, pass, err_cnt, first_err_addr.
  - The latency pipeline is cleared.
  - Reset asserted mid-sweep aborts the sweep with no partial done.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start = 1, go to READ.
  - Clear err_cnt, first_err_addr and pass; set busy = 1.
  - address_b = 0 and rden_b = 1 are registered on the same edge.
- READ:
  - Each cycle, address_b increments by 1 with rden_b = 1.
  - When address_b == DEPTH-1 is issued, the next edge sets rden_b = 0 and goes to DRAIN.
  - address_b holds at DEPTH-1; it never wraps to 0 inside a sweep.
- Pipeline:
  - A valid bit and address tag are shifted RD_LAT+1 stages: one stage for the RAM input register plus RD_LAT.
  - A compare happens in the cycle the valid bit exits the pipeline.
  - The compare checks q against (tag + SEED) truncated to DW bits.
- DRAIN:
  - Waits until the pipeline is empty (all valid bits 0).
  - Then goes to DONE, sets done = 1, busy = 0, and pass = (err_cnt == 0) on the same edge.
  - The final compare's result is included in pass.
- DONE:
  - Outputs hold.
  - start re-enters the sweep exactly as from IDLE: done drops the cycle after start.
- Timing:
  - Total sweep is DEPTH + RD_LAT + 2 cycles from start to done.
  - Reference case: 1026 + RD_LAT cycles for DEPTH = 1024.
- Mismatch handling:
  - On a mismatch, err_cnt increments with saturation.
  - first_err_addr is captured only when err_cnt == 0 before the increment.
- start during READ or DRAIN is ignored; there is no restart and no queuing.
- start asserted for more than one cycle while in IDLE or DONE: only the first cycle is acted upon. It is not re-accepted until DONE is reached again.
- Widths:
  - Expected-data arithmetic wraps modulo 2^DW, so address 256 expects 0 when SEED = 0 and DW = 8.
  - Address arithmetic is AW bits.

Test Plan:
- Clean sweep: RAM model preloaded with mem[a] = a[7:0], RD_LAT = 2, pulse start -> address_b steps 0..1023, rden_b high for 1024 cycles, done at start + 1028 cycles, pass = 1, err_cnt = 0.
- Injected errors: mem[5] = 8'hFF and mem[700] = 8'h00, rest correct -> err_cnt = 2, first_err_addr = 5, pass = 0.
- Latency sweep: repeat the clean sweep with RD_LAT = 1 and RD_LAT = 4 (model matched) -> pass = 1; done at start + 1027 and start + 1030 cycles respectively.
- Ignored start: extra start pulses at cycles 10 and 1025 after the first -> single sweep, done timing unchanged. A start one cycle after done -> done drops next cycle, new sweep from address 0 with counters cleared.
- Reset mid-sweep: rst_n low at address 400 for 3 cycles -> all outputs 0 immediately (asynchronously); after release stays IDLE with no done until a new start.
- SEED/wrap: SEED = 3, mem[a] = (a + 3)[7:0] -> pass = 1. Same memory with SEED = 0 -> err_cnt = 1024, first_err_addr = 0.
